// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read data RAM between the CPU (port 0)
// and a debug/loader master (port 1) with bounded port-1 burst locking.
module dmem_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int IDX_W     = 6,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [IDX_W-1:0]  ram_idx,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_e;

  port_e            last;
  logic [CNT_W-1:0] burst_cnt;
  logic             rd0;
  logic             rd1;
  logic             g0;
  logic             g1;
  logic             unused_addr_bits;

  // Grants are gated by reset so an asynchronous reset drops them immediately.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (m0_req && m1_req) begin
      if (m1_lock && (last == PORT1) && (burst_cnt < BURST_MAX)) begin
        g1 = 1'b1;
      end else if (last == PORT1) begin
        g0 = 1'b1;
      end else begin
        g1 = 1'b1;
      end
    end else begin
      g0 = m0_req;
      g1 = m1_req;
    end
    if (!reset_n) begin
      g0 = 1'b0;
      g1 = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last      <= PORT1;
      burst_cnt <= '0;
      rd0       <= 1'b0;
      rd1       <= 1'b0;
    end else begin
      if (g0) begin
        last <= PORT0;
      end else if (g1) begin
        last <= PORT1;
      end
      if (g0 || !m1_lock) begin
        burst_cnt <= '0;
      end else if (g1 && m0_req && (burst_cnt < BURST_MAX)) begin
        burst_cnt <= burst_cnt + CNT_W'(1);
      end
      rd0 <= g0 & ~m0_we;
      rd1 <= g1 & ~m1_we;
    end
  end

  always_comb begin
    ram_en    = g0 | g1;
    ram_we    = 1'b0;
    ram_idx   = '0;
    ram_wdata = '0;
    if (g0) begin
      ram_we    = m0_we;
      ram_idx   = m0_addr[IDX_W+1:2];
      ram_wdata = m0_wdata;
    end else if (g1) begin
      ram_we    = m1_we;
      ram_idx   = m1_addr[IDX_W+1:2];
      ram_wdata = m1_wdata;
    end
  end

  assign m0_gnt    = g0;
  assign m1_gnt    = g1;
  assign m0_rvalid = rd0;
  assign m1_rvalid = rd1;
  assign m0_rdata  = rd0 ? ram_rdata : '0;
  assign m1_rdata  = rd1 ? ram_rdata : '0;

  // Byte offset and bits above the RAM index are deliberately dropped (addresses wrap).
  assign unused_addr_bits = ^{m0_addr[ADDR_W-1:IDX_W+2], m0_addr[1:0],
                              m1_addr[ADDR_W-1:IDX_W+2], m1_addr[1:0]};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed table-driven bench for dmem_arbiter with a behavioural synchronous RAM.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_req, m0_we;
  logic [31:0] m0_addr, m0_wdata;
  logic        m0_gnt, m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m1_req, m1_we, m1_lock;
  logic [31:0] m1_addr, m1_wdata;
  logic        m1_gnt, m1_rvalid;
  logic [31:0] m1_rdata;
  logic        ram_en, ram_we;
  logic [5:0]  ram_idx;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic [31:0] mem [64];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        r0, w0;
    logic [31:0] a0, d0;
    logic        r1, w1, l1;
    logic [31:0] a1, d1;
    logic        eg0, eg1, erv0, erv1;
    logic [31:0] erd0, erd1;
    logic [5:0]  eidx;
    logic [31:0] ecnt;
  } vec_t;

  vec_t tbl[$];

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .IDX_W(6), .MAX_BURST(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_idx(ram_idx), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM; reset preloads word i with 0x100+i.
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h100 + i;
    end else if (ram_en) begin
      if (ram_we) mem[ram_idx] <= ram_wdata;
      else        ram_rdata    <= mem[ram_idx];
    end
  end

  function automatic vec_t mk(input logic r0, w0, input logic [31:0] a0, d0,
                              input logic r1, w1, l1, input logic [31:0] a1, d1,
                              input logic eg0, eg1,
                              input logic erv0, input logic [31:0] erd0,
                              input logic erv1, input logic [31:0] erd1,
                              input logic [5:0] eidx, input logic [31:0] ecnt);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
    v.eg0 = eg0; v.eg1 = eg1; v.erv0 = erv0; v.erd0 = erd0;
    v.erv1 = erv1; v.erd1 = erd1; v.eidx = eidx; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r0, w0, input logic [31:0] a0, d0,
                       input logic r1, w1, l1, input logic [31:0] a1, d1);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " m0_gnt"}, 32'(m0_gnt), 0);
    chk({tag, " m1_gnt"}, 32'(m1_gnt), 0);
    chk({tag, " m0_rvalid"}, 32'(m0_rvalid), 0);
    chk({tag, " m1_rvalid"}, 32'(m1_rvalid), 0);
    chk({tag, " m0_rdata"}, m0_rdata, 0);
    chk({tag, " m1_rdata"}, m1_rdata, 0);
    chk({tag, " ram_en"}, 32'(ram_en), 0);
    chk({tag, " ram_we"}, 32'(ram_we), 0);
    chk({tag, " ram_idx"}, 32'(ram_idx), 0);
    chk({tag, " ram_wdata"}, ram_wdata, 0);
  endtask

  task automatic apply(input int n, input vec_t v);
    string t;
    logic exp_we;
    logic [31:0] exp_wd;
    t = $sformatf("v%0d", n);
    drive(v.r0, v.w0, v.a0, v.d0, v.r1, v.w1, v.l1, v.a1, v.d1);
    exp_we = v.eg0 ? v.w0 : (v.eg1 ? v.w1 : 1'b0);
    exp_wd = v.eg0 ? v.d0 : (v.eg1 ? v.d1 : 32'h0);
    @(negedge clk);
    chk({t, " m0_gnt"}, 32'(m0_gnt), 32'(v.eg0));
    chk({t, " m1_gnt"}, 32'(m1_gnt), 32'(v.eg1));
    chk({t, " m0_rvalid"}, 32'(m0_rvalid), 32'(v.erv0));
    chk({t, " m1_rvalid"}, 32'(m1_rvalid), 32'(v.erv1));
    chk({t, " m0_rdata"}, m0_rdata, v.erd0);
    chk({t, " m1_rdata"}, m1_rdata, v.erd1);
    chk({t, " ram_en"}, 32'(ram_en), 32'(v.eg0 | v.eg1));
    chk({t, " ram_we"}, 32'(ram_we), 32'(exp_we));
    chk({t, " ram_idx"}, 32'(ram_idx), 32'(v.eidx));
    chk({t, " ram_wdata"}, ram_wdata, exp_wd);
    chk({t, " burst_cnt"}, 32'(dut.burst_cnt), v.ecnt);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1, 0, 32'h8, 0, 1, 0, 0, 32'h14, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    chk("reset burst_cnt", 32'(dut.burst_cnt), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Contention from reset, no lock: grants alternate starting with port 0.
    tbl.push_back(mk(1,0,32'd8, 0, 1,0,0,32'd20,0, 1,0, 0,0,      0,0,      6'd2, 0));
    tbl.push_back(mk(1,0,32'd12,0, 1,0,0,32'd20,0, 0,1, 1,'h102,  0,0,      6'd5, 0));
    tbl.push_back(mk(1,0,32'd12,0, 1,0,0,32'd24,0, 1,0, 0,0,      1,'h105,  6'd3, 0));
    tbl.push_back(mk(1,0,32'd16,0, 1,0,0,32'd24,0, 0,1, 1,'h103,  0,0,      6'd6, 0));
    tbl.push_back(mk(1,0,32'd16,0, 0,0,0,0,0,       1,0, 0,0,      1,'h106,  6'd4, 0));
    tbl.push_back(mk(0,0,0,0,      0,0,0,0,0,       0,0, 1,'h104,  0,0,      6'd0, 0));
    // Port 0 write 7 to addr 84, read it back.
    tbl.push_back(mk(1,1,32'd84,7, 0,0,0,0,0,       1,0, 0,0,      0,0,      6'd21, 0));
    tbl.push_back(mk(1,0,32'd84,0, 0,0,0,0,0,       1,0, 0,0,      0,0,      6'd21, 0));
    tbl.push_back(mk(0,0,0,0,      0,0,0,0,0,       0,0, 1,7,      0,0,      6'd0, 0));
    // Wrapped, misaligned port-1 write; port 0 reads it at addr 84.
    tbl.push_back(mk(0,0,0,0,      1,1,0,32'h156,'hA5, 0,1, 0,0,   0,0,      6'd21, 0));
    tbl.push_back(mk(1,0,32'd84,0, 0,0,0,0,0,       1,0, 0,0,      0,0,      6'd21, 0));
    tbl.push_back(mk(0,0,0,0,      0,0,0,0,0,       0,0, 1,'hA5,   0,0,      6'd0, 0));
    // Lone locked port-1 win, then an 8-grant burst while port 0 waits.
    tbl.push_back(mk(0,0,0,0,      1,1,1,32'd36,'h50, 0,1, 0,0,    0,0,      6'd9, 0));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(1,0,0,0, 1,1,1,32'((10 + k) * 4),32'(k), 0,1, 0,0, 0,0, 6'(10 + k), 32'(k)));
    tbl.push_back(mk(1,0,0,0,      1,1,1,32'd72,'h18, 1,0, 0,0,    0,0,      6'd0, 8));
    tbl.push_back(mk(1,0,0,0,      1,1,1,32'd72,'h18, 0,1, 1,'h100, 0,0,     6'd18, 0));
    tbl.push_back(mk(1,0,0,0,      1,1,1,32'd76,'h19, 0,1, 0,0,    0,0,      6'd19, 1));
    tbl.push_back(mk(1,0,0,0,      1,1,1,32'd80,'h1A, 0,1, 0,0,    0,0,      6'd20, 2));
    // Lock drops after 3 burst grants: port 0 wins and the counter clears.
    tbl.push_back(mk(1,0,0,0,      1,1,0,32'd84,'h1B, 1,0, 0,0,    0,0,      6'd0, 3));
    tbl.push_back(mk(0,0,0,0,      0,0,0,0,0,       0,0, 1,'h100,  0,0,      6'd0, 0));

    foreach (tbl[i]) apply(i, tbl[i]);

    // Reset asserted the cycle after a port-0 read grant loses the read.
    drive(1, 0, 32'd8, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("midrd m0_gnt", 32'(m0_gnt), 1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    drive(1, 0, 32'd8, 0, 1, 0, 0, 32'd20, 0);
    #1;
    chk_all_zero("midrst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("postrst m0_gnt", 32'(m0_gnt), 1);
    chk("postrst m1_gnt", 32'(m1_gnt), 0);
    chk("postrst m0_rvalid", 32'(m0_rvalid), 0);
    chk("postrst ram_idx", 32'(ram_idx), 2);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("postrst rd m0_rvalid", 32'(m0_rvalid), 1);
    chk("postrst rd m0_rdata", m0_rdata, 32'h102);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
